// File: rtl/m_seg_scan_ctrl.sv
`default_nettype none
// m_seg_scan_ctrl: pops bytes from a circular queue and scans the last two onto a 4-digit 7-segment display.
// Optional feature macro: SEG_LEADING_BLANK_EN (blank digits above the most-significant nonzero nibble).
module m_seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int HOLD_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_empty,
  input  logic [7:0] i_rd_data,
  output logic       o_rd_en,
  output logic [6:0] o_seg,
  output logic [3:0] o_an,
  output logic       o_dp
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_POP     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   digit_reg_q, digit_reg_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          blank;

  function automatic logic [6:0] f_hex(input logic [3:0] n);
    case (n)
      4'h0: f_hex = 7'b1000000;  4'h1: f_hex = 7'b1111001;
      4'h2: f_hex = 7'b0100100;  4'h3: f_hex = 7'b0110000;
      4'h4: f_hex = 7'b0011001;  4'h5: f_hex = 7'b0010010;
      4'h6: f_hex = 7'b0000010;  4'h7: f_hex = 7'b1111000;
      4'h8: f_hex = 7'b0000000;  4'h9: f_hex = 7'b0010000;
      4'hA: f_hex = 7'b0001000;  4'hB: f_hex = 7'b0000011;
      4'hC: f_hex = 7'b1000110;  4'hD: f_hex = 7'b0100001;
      4'hE: f_hex = 7'b0000110;  default: f_hex = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    digit_reg_d = digit_reg_q;
    case (state_q)
      ST_IDLE:    if (!i_empty) state_d = ST_POP;
      ST_POP:     state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        // The queue presents the popped byte during this cycle.
        digit_reg_d = {digit_reg_q[7:0], i_rd_data};
        hold_cnt_d  = '0;
        state_d     = ST_HOLD;
      end
      default: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_IDLE;
        else                         hold_cnt_d = hold_cnt_q + HW'(1);
      end
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  always_comb begin
    blank = 1'b0;
`ifdef SEG_LEADING_BLANK_EN
    case (idx_q)
      2'd3:    blank = (digit_reg_q[15:12] == 4'h0);
      2'd2:    blank = (digit_reg_q[15:8] == 8'h00);
      2'd1:    blank = (digit_reg_q[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
`endif
    // Anode and segments are both derived from idx_q so they switch on the same edge.
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'b1111111 : f_hex(digit_reg_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      digit_reg_q <= 16'h0000;
      an_q        <= 4'b1110;
      seg_q       <= 7'b1000000;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      digit_reg_q <= digit_reg_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign o_rd_en = (state_q == ST_POP);
  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_m_seg_scan_ctrl.sv
`default_nettype none
// tb_m_seg_scan_ctrl: directed stimulus with a cycle-level display/queue model and literal spot checks.
module tb_m_seg_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int HOLD_CYC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_empty;
  logic [7:0] i_rd_data;
  logic       o_rd_en;
  logic [6:0] o_seg;
  logic [3:0] o_an;
  logic       o_dp;

  m_seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .i_empty(i_empty), .i_rd_data(i_rd_data),
    .o_rd_en(o_rd_en), .o_seg(o_seg), .o_an(o_an), .o_dp(o_dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic [6:0] seg_of(input logic [15:0] v, input int s);
    logic [15:0] sh;
    sh = v >> (4 * s);
`ifdef SEG_LEADING_BLANK_EN
    if (s != 0 && sh == 16'd0) return 7'b1111111;
`endif
    return hex_tab[int'(sh & 16'h000F)];
  endfunction

  // Model: cycles since reset release, displayed value, and cycles left before the controller is idle.
  int          cyc;
  int          busy;
  int          slot;
  logic [15:0] m_val;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_rd;
  bit          model_ok = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0; busy = 0; m_val = 16'h0000;
      e_an = 4'b1110; e_seg = seg_of(16'h0000, 0); e_rd = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      slot  = (cyc / SCAN_DIV) % 4;
      e_an  = ~(4'b0001 << slot);
      e_seg = seg_of(m_val, slot);
      if (busy == HOLD_CYC + 1) m_val = {m_val[7:0], i_rd_data};
      if (busy > 0) busy--;
      else if (!i_empty) busy = HOLD_CYC + 2;
      e_rd = (busy == HOLD_CYC + 2);
      cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("rd_en", 16'(o_rd_en), 16'(e_rd));
      chk("an", 16'(o_an), 16'(e_an));
      chk("seg", 16'(o_seg), 16'(e_seg));
      chk("dp", 16'(o_dp), 16'd1);
    end
  end

  // Queue responder and pop monitor.
  logic [7:0] byte_q[$];
  bit         prev_rd = 1'b0;
  int         pulses = 0;
  int         ncyc = 0;
  int         pulse_t[$];

  initial begin
    i_rd_data = 8'hEE;
    forever begin
      @(negedge clk);
      if (prev_rd && byte_q.size() > 0) i_rd_data = byte_q.pop_front();
      else                              i_rd_data = 8'hEE;
      prev_rd = (o_rd_en === 1'b1);
      if (prev_rd) begin pulses++; pulse_t.push_back(ncyc); end
      ncyc++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
  endtask

  task automatic pop_one(input logic [7:0] b, input string nm);
    int n = 0;
    byte_q.push_back(b);
    i_empty = 1'b0;
    tick();
    while (o_rd_en !== 1'b1 && n < 30) begin tick(); n++; end
    i_empty = 1'b1;
    if (n >= 30) chk({nm, "_pop_timeout"}, 16'(o_rd_en), 16'd1);
  endtask

  task automatic show_digit(input logic [3:0] an, input logic [6:0] exp, input string nm);
    int n = 0;
    while (o_an !== an && n < 40) begin tick(); n++; end
    chk({nm, "_an"}, 16'(o_an), 16'(an));
    chk(nm, 16'(o_seg), 16'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p0;

  initial begin
    rst = 1'b1; i_empty = 1'b1;
    tick(3);
    chk("rst_an", 16'(o_an), 16'b1110);
    chk("rst_seg", 16'(o_seg), 16'b1000000);
    chk("rst_rd_en", 16'(o_rd_en), 16'd0);
    chk("rst_dp", 16'(o_dp), 16'd1);
    rst = 1'b0;
    tick(4); chk("scan_e4", 16'(o_an), 16'b1110);
    tick(1); chk("scan_e5", 16'(o_an), 16'b1101);
    tick(4); chk("scan_e9", 16'(o_an), 16'b1011);
    tick(4); chk("scan_e13", 16'(o_an), 16'b0111);
    tick(4); chk("scan_e17", 16'(o_an), 16'b1110);

    // Single pop of 0x3C
    p0 = pulses;
    pop_one(8'h3C, "p3c");
    tick(15);
    chk("p3c_count", 16'(pulses - p0), 16'd1);
    show_digit(4'b1101, 7'b0110000, "p3c_d1");
    show_digit(4'b1110, 7'b1000110, "p3c_d0");

    // Back-to-back bytes with i_empty held low
    p0 = pulses;
    byte_q.push_back(8'h12); byte_q.push_back(8'hAB);
    i_empty = 1'b0;
    for (int n = 0; n < 40 && pulses - p0 < 2; n++) tick();
    i_empty = 1'b1;
    chk("spacing_count", 16'(pulses - p0), 16'd2);
    if (pulse_t.size() >= 2)
      chk("spacing", 16'(pulse_t[pulse_t.size()-1] - pulse_t[pulse_t.size()-2]), 16'd11);
    tick(15);
    show_digit(4'b0111, 7'b1111001, "d3_1");
    show_digit(4'b1011, 7'b0100100, "d2_2");
    show_digit(4'b1101, 7'b0001000, "d1_A");
    show_digit(4'b1110, 7'b0000011, "d0_b");

    // Empty gating, then an i_empty glitch during HOLD
    p0 = pulses;
    tick(100);
    chk("empty_gate", 16'(pulses - p0), 16'd0);
    show_digit(4'b1110, 7'b0000011, "empty_d0");
    pop_one(8'h5F, "p5f");
    tick(4);
    i_empty = 1'b0; tick(); i_empty = 1'b1;
    tick(20);
    chk("glitch_count", 16'(pulses - p0), 16'd1);
    show_digit(4'b1110, 7'b0001110, "p5f_d0");
    show_digit(4'b0111, 7'b0001000, "p5f_d3");

    // Reset asserted during CAPTURE of 0xFF
    pop_one(8'hFF, "pff");
    tick();
    rst = 1'b1;
    tick(3);
    chk("mid_rst_seg", 16'(o_seg), 16'b1000000);
    rst = 1'b0;
`ifdef SEG_LEADING_BLANK_EN
    show_digit(4'b0111, 7'b1111111, "mr_d3");
    show_digit(4'b1011, 7'b1111111, "mr_d2");
    show_digit(4'b1101, 7'b1111111, "mr_d1");
`else
    show_digit(4'b0111, 7'b1000000, "mr_d3");
    show_digit(4'b1011, 7'b1000000, "mr_d2");
    show_digit(4'b1101, 7'b1000000, "mr_d1");
`endif
    show_digit(4'b1110, 7'b1000000, "mr_d0");
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/m_seg_scan_ctrl.md
M_SEG_SCAN_CTRL -- requirements
Module: m_seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit-scan slot; legal range 2..2^20.
REQ-002 Parameter HOLD_CYC, default 50000000: minimum clk cycles between the end of one capture and the next queue pop; legal range 1..2^27.
REQ-003 clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 i_empty  input  1: circular queue empty flag; 1 means no data to pop.
REQ-006 i_rd_data  input  8: circular queue read data; valid exactly one cycle after o_rd_en is high.
REQ-007 o_rd_en  output  1: pop request to the circular queue; a one-cycle pulse.
REQ-008 o_seg  output  7: segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 o_an  output  4: digit anode select, one-hot active-low; bit0 is the rightmost digit.
REQ-010 o_dp  output  1: decimal point, active-low; held at 1 (off) at all times.

Function
REQ-011 Control FSM states: IDLE, POP, CAPTURE, HOLD.
- IDLE -> POP when i_empty=0.
- POP -> CAPTURE unconditionally.
- CAPTURE -> HOLD unconditionally.
- HOLD -> IDLE once the hold counter reaches HOLD_CYC-1.
REQ-012 o_rd_en is 1 only in state POP, so every pop is exactly one cycle wide and at most one pop is in flight.
REQ-013 i_empty is sampled only in IDLE; i_empty changes in any other state have no effect.
REQ-014 In CAPTURE, the 16-bit digit register becomes {digit_reg[7:0], i_rd_data}: the newest byte shows as digits 1:0 and the previous byte shifts to digits 3:2.
REQ-015 The hold counter clears on entry to HOLD and counts 0..HOLD_CYC-1.
REQ-016 The scan divider counts 0..SCAN_DIV-1 and wraps.
- On each wrap, the 2-bit digit index increments modulo 4 (3 -> 0).
- The scan runs independently of the FSM state.
REQ-017 o_an equals ~(4'b0001 << index).
- o_seg is the registered hex decode of nibble digit_reg[4*index+3 : 4*index].
- o_an and o_seg update on the same edge, so there is no cross-digit ghosting.
REQ-018 Hex decode table (active-low gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
REQ-019 A digit_reg update that occurs mid-slot appears on the active digit on the next clk edge; scan timing is not disturbed.

Reset
REQ-020 While rst=1, the following values are forced and held:
- FSM = IDLE, digit_reg = 0, index = 0, scan and hold counters = 0.
- o_rd_en = 0, o_an = 4'b1110, o_seg = 7'b1000000, o_dp = 1.
REQ-021 If reset is asserted in POP or CAPTURE, the popped byte is discarded and not displayed; after release, the FSM restarts from IDLE.

Configuration
REQ-022 Macro SEG_LEADING_BLANK_EN: when defined, leading-zero blanking is applied.
- Any digit above the most-significant nonzero nibble outputs o_seg = 7'b1111111.
- Digit 0 is never blanked.
- Under reset the display shows "   0".
- When not defined, all four digits always display their hex value.

Verification (SCAN_DIV=4, HOLD_CYC=8)
REQ-023 Reset: assert rst for 3 cycles -> o_an=1110, o_seg=1000000, o_rd_en=0, o_dp=1; after release, o_an steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, every 4 cycles.
REQ-024 Pop handshake: i_empty=0 with i_rd_data=8'h3C presented one cycle after o_rd_en -> exactly one 1-cycle o_rd_en pulse; afterwards digit1 decodes 0110000 ('3') and digit0 decodes 1000110 ('C').
REQ-025 Hold spacing: i_empty held 0 with bytes 8'h12 then 8'hAB -> o_rd_en pulses are 11 cycles apart (POP + CAPTURE + 8 HOLD + IDLE); display = 12AB (digits 3..0).
REQ-026 Empty gating: i_empty=1 for 100 cycles -> o_rd_en stays 0 and the display is unchanged; a 1-cycle i_empty=0 glitch during HOLD produces no pop.
REQ-027 Reset mid-op: assert rst in the CAPTURE cycle of byte 8'hFF -> digit_reg=0000 after reset; with SEG_LEADING_BLANK_EN, digits 3..1 = 1111111 and digit 0 = 1000000.
